// File: rtl/ceespu_dmem_ctrl.sv
// Data-memory controller for the ceespu core: byte-writable local RAM below EXT_BASE,
// stalling req/ack external bus at or above it, with a bus-error timeout.
module ceespu_dmem_ctrl #(
  parameter int unsigned RAM_WORDS = 4096,
  parameter logic [15:0] EXT_BASE  = 16'h8000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [15:0] I_dmemAddress,
  input  logic [31:0] I_dmemWData,
  input  logic        I_dmemE,
  input  logic [3:0]  I_dmemWe,
  output logic [31:0] O_dmemData,
  output logic        O_dmemBusy,
  output logic        O_extReq,
  output logic [15:0] O_extAddr,
  output logic [31:0] O_extWData,
  output logic [3:0]  O_extWe,
  input  logic        I_extAck,
  input  logic [31:0] I_extRData,
  output logic        O_busErr
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic        w_busy;
  logic        w_start;
  logic        w_ack;
  logic        w_timeout;
  logic        w_is_ext;
  logic        w_local_acc;
  logic        w_done_acc;
  logic [AW-1:0] w_idx;
  logic        w_unused_addr;

  logic [31:0] r_mem [RAM_WORDS];
  logic [31:0] r_ramQ;
  logic [31:0] r_extQ;
  logic [31:0] r_cap;
  logic        r_sel;
  logic [7:0]  r_cnt;
  logic        r_extReq;
  logic [15:0] r_extAddr;
  logic [31:0] r_extWData;
  logic [3:0]  r_extWe;
  logic        r_busErr;

  assign w_is_ext      = I_dmemAddress >= EXT_BASE;
  assign w_idx         = I_dmemAddress[AW+1:2];
  assign w_unused_addr = ^I_dmemAddress[1:0];
  assign w_local_acc   = I_dmemE & (r_state == StIdle) & ~w_is_ext;
  // DONE hands the still-held external request back to the core without re-issuing it.
  assign w_done_acc    = I_dmemE & (r_state == StDone);

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_start      = 1'b0;
    w_ack        = 1'b0;
    w_timeout    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (I_dmemE && w_is_ext) begin
          w_busy       = 1'b1;
          w_start      = 1'b1;
          w_state_next = StWait;
        end
      end
      StWait: begin
        w_busy = 1'b1;
        if (I_extAck) begin
          w_ack        = 1'b1;
          w_state_next = StDone;
        end else if (r_cnt == TO_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge I_clk) begin
    if (w_local_acc) begin
      for (int i = 0; i < 4; i++) begin
        if (I_dmemWe[i]) r_mem[w_idx][8*i +: 8] <= I_dmemWData[8*i +: 8];
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_ramQ     <= 32'h0;
      r_extQ     <= 32'h0;
      r_cap      <= 32'h0;
      r_sel      <= 1'b0;
      r_cnt      <= 8'h0;
      r_extReq   <= 1'b0;
      r_extAddr  <= 16'h0;
      r_extWData <= 32'h0;
      r_extWe    <= 4'h0;
      r_busErr   <= 1'b0;
    end else begin
      r_busErr <= w_timeout;
      if (w_start) begin
        r_extAddr  <= {I_dmemAddress[15:2], 2'b00};
        r_extWData <= I_dmemWData;
        r_extWe    <= I_dmemWe;
        r_extReq   <= 1'b1;
        r_cnt      <= 8'h0;
      end else if (r_state == StWait) begin
        r_cnt <= r_cnt + 8'd1;
        if (w_ack || w_timeout) r_extReq <= 1'b0;
      end
      if (w_ack) begin
        r_cap <= (r_extWe != 4'h0) ? 32'h0 : I_extRData;
      end else if (w_timeout) begin
        r_cap <= 32'hDEADBEEF;
      end
      if (w_local_acc) begin
        r_sel  <= 1'b0;
        r_ramQ <= (I_dmemWe != 4'h0) ? 32'h0 : r_mem[w_idx];
      end else if (w_done_acc) begin
        r_sel  <= 1'b1;
        r_extQ <= r_cap;
      end
    end
  end

  assign O_dmemData = r_sel ? r_extQ : r_ramQ;
  assign O_dmemBusy = w_busy;
  assign O_extReq   = r_extReq;
  assign O_extAddr  = r_extAddr;
  assign O_extWData = r_extWData;
  assign O_extWe    = r_extWe;
  assign O_busErr   = r_busErr;

endmodule

// File: tb/tb_ceespu_dmem_ctrl.sv
// Scoreboard bench for ceespu_dmem_ctrl: local RAM, external bus, timeout and reset paths.
module tb_ceespu_dmem_ctrl;

  localparam int unsigned TO = 8;

  logic        I_clk;
  logic        I_rst;
  logic [15:0] I_dmemAddress;
  logic [31:0] I_dmemWData;
  logic        I_dmemE;
  logic [3:0]  I_dmemWe;
  logic [31:0] O_dmemData;
  logic        O_dmemBusy;
  logic        O_extReq;
  logic [15:0] O_extAddr;
  logic [31:0] O_extWData;
  logic [3:0]  O_extWe;
  logic        I_extAck;
  logic [31:0] I_extRData;
  logic        O_busErr;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];
  logic [31:0] model [int];
  logic [31:0] last_data = 32'h0;

  ceespu_dmem_ctrl #(
    .RAM_WORDS(4096),
    .EXT_BASE (16'h8000),
    .TIMEOUT  (TO)
  ) dut (
    .I_clk        (I_clk),
    .I_rst        (I_rst),
    .I_dmemAddress(I_dmemAddress),
    .I_dmemWData  (I_dmemWData),
    .I_dmemE      (I_dmemE),
    .I_dmemWe     (I_dmemWe),
    .O_dmemData   (O_dmemData),
    .O_dmemBusy   (O_dmemBusy),
    .O_extReq     (O_extReq),
    .O_extAddr    (O_extAddr),
    .O_extWData   (O_extWData),
    .O_extWe      (O_extWe),
    .I_extAck     (I_extAck),
    .I_extRData   (I_extRData),
    .O_busErr     (O_busErr)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic int widx(input logic [15:0] a);
    return int'(a[13:2]);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  // ack_at = n acks in the n-th cycle that O_extReq is high (0 = never).
  task automatic access(input logic [15:0] addr, input logic [31:0] wd, input logic [3:0] we,
                        input int ack_at, input logic [31:0] ack_data,
                        output int n_busy, output int n_req, output int n_err);
    int guard;
    n_busy = 0; n_req = 0; n_err = 0; guard = 0;
    I_dmemAddress = addr; I_dmemWData = wd; I_dmemWe = we; I_dmemE = 1'b1; I_extAck = 1'b0;
    forever begin
      #1;
      if (O_busErr) n_err++;
      if (O_extReq) begin
        n_req++;
        if (n_req == ack_at) begin I_extAck = 1'b1; I_extRData = ack_data; end
      end
      if (!O_dmemBusy) break;
      n_busy++;
      @(posedge I_clk); #1;
      I_extAck = 1'b0;
      guard++;
      if (guard > 400) begin
        checks++; errors++;
        $display("FAIL access_bound busy still %b after %0d cycles, required 0", O_dmemBusy, guard);
        break;
      end
    end
    @(posedge I_clk); #1;
    I_extAck = 1'b0; I_dmemE = 1'b0; I_dmemWe = 4'h0;
  endtask

  task automatic test_reset();
    I_rst = 1'b1; I_dmemE = 1'b0; I_dmemWe = 4'h0; I_dmemAddress = 16'h0;
    I_dmemWData = 32'h0; I_extAck = 1'b0; I_extRData = 32'h0;
    repeat (3) @(posedge I_clk);
    #1; I_rst = 1'b0;
    checks++; if (O_dmemData !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", O_dmemData); end
    checks++; if ({O_dmemBusy, O_extReq, O_busErr} !== 3'b000) begin errors++;
      $display("FAIL reset_ctl got busy/req/err %b exp 000", {O_dmemBusy, O_extReq, O_busErr}); end
    checks++; if ({O_extAddr, O_extWData, O_extWe} !== 52'h0) begin errors++;
      $display("FAIL reset_ext got %h/%h/%h exp 0", O_extAddr, O_extWData, O_extWe); end
  endtask

  task automatic test_local_word();
    int nb, nr, ne;
    logic [31:0] e;
    model[widx(16'h0010)] = 32'h12345678;
    sb.push_back(32'h0);
    access(16'h0010, 32'h12345678, 4'hF, 0, 32'h0, nb, nr, ne);
    e = sb.pop_front(); last_data = e;
    checks++; if (O_dmemData !== e) begin errors++; $display("FAIL local_wr_data got %h exp %h", O_dmemData, e); end
    sb.push_back(model[widx(16'h0010)]);
    access(16'h0010, 32'h0, 4'h0, 0, 32'h0, nb, nr, ne);
    e = sb.pop_front(); last_data = e;
    checks++; if (O_dmemData !== e) begin errors++; $display("FAIL local_rd_data got %h exp %h", O_dmemData, e); end
    checks++; if (nb !== 0) begin errors++; $display("FAIL local_busy got %0d exp 0", nb); end
    // 0x4010 aliases word 4 in a 4096-word RAM
    sb.push_back(model[widx(16'h4010)]);
    access(16'h4010, 32'h0, 4'h0, 0, 32'h0, nb, nr, ne);
    e = sb.pop_front(); last_data = e;
    checks++; if (O_dmemData !== e) begin errors++; $display("FAIL local_alias got %h exp %h", O_dmemData, e); end
    model[widx(16'h7FFC)] = 32'h0F1E2D3C;
    access(16'h7FFC, 32'h0F1E2D3C, 4'hF, 0, 32'h0, nb, nr, ne);
    sb.push_back(model[widx(16'h7FFC)]);
    access(16'h7FFC, 32'h0, 4'h0, 0, 32'h0, nb, nr, ne);
    e = sb.pop_front(); last_data = e;
    checks++; if (O_dmemData !== e || nb !== 0 || nr !== 0) begin errors++;
      $display("FAIL local_top got %h busy %0d req %0d exp %h 0 0", O_dmemData, nb, nr, e); end
  endtask

  task automatic test_local_byte();
    int nb, nr, ne;
    logic [31:0] e;
    model[widx(16'h0010)] = merge(model[widx(16'h0010)], 32'h0000AB00, 4'b0010);
    sb.push_back(32'h0);
    access(16'h0010, 32'h0000AB00, 4'b0010, 0, 32'h0, nb, nr, ne);
    e = sb.pop_front(); last_data = e;
    checks++; if (O_dmemData !== e) begin errors++; $display("FAIL byte_wr_data got %h exp %h", O_dmemData, e); end
    sb.push_back(model[widx(16'h0010)]);
    access(16'h0010, 32'h0, 4'h0, 0, 32'h0, nb, nr, ne);
    e = sb.pop_front(); last_data = e;
    checks++; if (O_dmemData !== e) begin errors++; $display("FAIL byte_rd_data got %h exp %h", O_dmemData, e); end
  endtask

  task automatic test_idle_hold();
    int nb, nr, ne;
    logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      I_dmemE = 1'b0; I_dmemWe = 4'hF; I_dmemWData = $urandom;
      I_dmemAddress = (i % 2 == 0) ? 16'h0010 : 16'h8800;
      @(posedge I_clk); #1;
      checks++; if (O_dmemData !== last_data || O_dmemBusy !== 1'b0 || O_extReq !== 1'b0) begin
        errors++; $display("FAIL idle_hold got %h busy %b req %b exp %h 0 0",
                           O_dmemData, O_dmemBusy, O_extReq, last_data); end
    end
    I_dmemWe = 4'h0;
    sb.push_back(model[widx(16'h0010)]);
    access(16'h0010, 32'h0, 4'h0, 0, 32'h0, nb, nr, ne);
    e = sb.pop_front(); last_data = e;
    checks++; if (O_dmemData !== e) begin errors++; $display("FAIL idle_no_write got %h exp %h", O_dmemData, e); end
  endtask

  task automatic test_stray_ack();
    I_dmemE = 1'b0; I_extAck = 1'b1; I_extRData = 32'h77777777;
    @(posedge I_clk); #1;
    I_extAck = 1'b0;
    checks++; if (O_dmemData !== last_data || O_extReq !== 1'b0 || O_busErr !== 1'b0) begin
      errors++; $display("FAIL stray_ack got %h req %b err %b exp %h 0 0",
                         O_dmemData, O_extReq, O_busErr, last_data); end
  endtask

  task automatic test_ext_read();
    int nb, nr, ne;
    logic [31:0] e;
    sb.push_back(32'hCAFEF00D);
    access(16'h8004, 32'h0, 4'h0, 3, 32'hCAFEF00D, nb, nr, ne);
    e = sb.pop_front(); last_data = e;
    checks++; if (O_dmemData !== e) begin errors++; $display("FAIL ext_rd_data got %h exp %h", O_dmemData, e); end
    checks++; if (nb !== 4 || nr !== 3 || ne !== 0) begin errors++;
      $display("FAIL ext_rd_timing got busy %0d req %0d err %0d exp 4 3 0", nb, nr, ne); end
    checks++; if (O_extAddr !== 16'h8004 || O_extWe !== 4'h0) begin errors++;
      $display("FAIL ext_rd_addr got %h we %h exp 8004 0", O_extAddr, O_extWe); end
  endtask

  task automatic test_ext_write();
    int nb, nr, ne;
    logic [31:0] e;
    sb.push_back(32'h0);
    access(16'h8000, 32'hA5A55A5A, 4'hF, 1, 32'h11111111, nb, nr, ne);
    e = sb.pop_front(); last_data = e;
    checks++; if (O_dmemData !== e) begin errors++; $display("FAIL ext_wr_data got %h exp %h", O_dmemData, e); end
    checks++; if (nb !== 2 || nr !== 1) begin errors++;
      $display("FAIL ext_wr_timing got busy %0d req %0d exp 2 1", nb, nr); end
    checks++; if (O_extAddr !== 16'h8000 || O_extWData !== 32'hA5A55A5A || O_extWe !== 4'hF) begin
      errors++; $display("FAIL ext_wr_fields got %h %h %h exp 8000 a5a55a5a f",
                         O_extAddr, O_extWData, O_extWe); end
  endtask

  task automatic test_timeout();
    int nb, nr, ne;
    logic [31:0] e;
    sb.push_back(32'hDEADBEEF);
    access(16'h9000, 32'h0, 4'h0, 0, 32'h0, nb, nr, ne);
    e = sb.pop_front(); last_data = e;
    checks++; if (O_dmemData !== e) begin errors++; $display("FAIL timeout_data got %h exp %h", O_dmemData, e); end
    checks++; if (nb !== TO + 1 || nr !== TO || ne !== 1) begin errors++;
      $display("FAIL timeout_timing got busy %0d req %0d err %0d exp %0d %0d 1", nb, nr, ne, TO + 1, TO); end
    checks++; if (O_busErr !== 1'b0) begin errors++; $display("FAIL timeout_pulse got %b exp 0", O_busErr); end
  endtask

  task automatic test_ack_timeout_race();
    int nb, nr, ne;
    logic [31:0] e;
    sb.push_back(32'h0BADCAFE);
    access(16'h9004, 32'h0, 4'h0, TO, 32'h0BADCAFE, nb, nr, ne);
    e = sb.pop_front(); last_data = e;
    checks++; if (O_dmemData !== e || ne !== 0) begin errors++;
      $display("FAIL race got %h err %0d exp %h 0", O_dmemData, ne, e); end
  endtask

  task automatic test_reset_in_wait();
    int nb, nr, ne;
    logic [31:0] e;
    I_dmemAddress = 16'h8100; I_dmemWe = 4'h0; I_dmemE = 1'b1;
    #1;
    checks++; if (O_dmemBusy !== 1'b1) begin errors++; $display("FAIL rst_wait_busy got %b exp 1", O_dmemBusy); end
    repeat (2) @(posedge I_clk);
    #1; I_rst = 1'b1; I_dmemE = 1'b0;
    @(posedge I_clk); #1;
    I_rst = 1'b0; last_data = 32'h0;
    checks++; if ({O_extReq, O_dmemBusy, O_busErr} !== 3'b000 || O_dmemData !== 32'h0) begin
      errors++; $display("FAIL rst_wait got req/busy/err %b data %h exp 000 0",
                         {O_extReq, O_dmemBusy, O_busErr}, O_dmemData); end
    sb.push_back(32'h13572468);
    access(16'h8104, 32'h0, 4'h0, 2, 32'h13572468, nb, nr, ne);
    e = sb.pop_front(); last_data = e;
    checks++; if (O_dmemData !== e || nb !== 3 || nr !== 2 || ne !== 0) begin errors++;
      $display("FAIL rst_restart got %h busy %0d req %0d err %0d exp %h 3 2 0", O_dmemData, nb, nr, ne, e); end
  endtask

  task automatic test_back_to_back();
    int nb, nr, ne, cyc;
    time t0;
    logic [31:0] e;
    logic [15:0] addrs [4] = '{16'h0010, 16'h8200, 16'h8204, 16'h7FFC};
    int          lats  [4] = '{0, 1, 5, 0};
    logic [31:0] rdat  [4] = '{32'h0, 32'h89ABCDEF, 32'h02468ACE, 32'h0};
    for (int i = 0; i < 4; i++)
      sb.push_back(lats[i] == 0 ? model[widx(addrs[i])] : rdat[i]);
    for (int i = 0; i < 4; i++) begin
      t0 = $time;
      access(addrs[i], 32'h0, 4'h0, lats[i], rdat[i], nb, nr, ne);
      cyc = int'(($time - t0) / 10);
      e = sb.pop_front(); last_data = e;
      checks++; if (O_dmemData !== e) begin errors++;
        $display("FAIL b2b_data[%0d] got %h exp %h", i, O_dmemData, e); end
      checks++; if (cyc !== (lats[i] == 0 ? 1 : 2 + lats[i])) begin errors++;
        $display("FAIL b2b_cycles[%0d] got %0d exp %0d", i, cyc, (lats[i] == 0 ? 1 : 2 + lats[i])); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_local_word();
    test_local_byte();
    test_idle_hold();
    test_stray_ack();
    test_ext_read();
    test_ext_write();
    test_timeout();
    test_ack_timeout_race();
    test_reset_in_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
